pwm_duty_capture: RTL and testbench

Receive-side counterpart of the motor PWM generator. It measures an incoming PWM waveform, such as a motor driver feedback or loop-back of the generated pwm bit, and reports the period in clk cycles and a 10-bit duty (0..1023), on the same scale as the generator's duty input. It is used for closed-loop checking of the motor drive and for on-board debug display.

---
 rtl/pwm_duty_capture_pkg.sv | 22 ++
 rtl/pwm_duty_capture_seq_divider.sv | 71 +++++++
 rtl/pwm_duty_capture.sv | 142 ++++++++++++++
 tb/tb_pwm_duty_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_capture_pkg.sv
// Shared constants for the motor PWM generator and its capture block.
package pwm_duty_capture_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } cap_state_t;

    // Full-scale duty code on the generator's 10-bit scale
    localparam int DUTY_FULL   = 1023;

    // Cycles without a rising edge before the input is declared stuck
    localparam int TIMEOUT_DEF = 4000;

    // Motor PWM timing, shared with the generator
    localparam int CLK_HZ         = 100_000_000;
    localparam int PWM_HZ         = 50_000;
    localparam int PWM_PERIOD_CYC = CLK_HZ / PWM_HZ;

endpackage

// File: rtl/pwm_duty_capture_seq_divider.sv
// Restoring unsigned divider: computes (num << FRAC_W) / den, one quotient
// bit per cycle, FRAC_W+1 iterations MSB first. The caller guarantees
// num <= den, so the quotient always fits in FRAC_W+1 bits.
module seq_divider #(
    parameter int W      = 32,
    parameter int FRAC_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      num,
    input  logic [W-1:0]      den,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W:0]   quo
);

    localparam int IT_W = $clog2(FRAC_W + 2);

    logic [W-1:0]      rem;
    logic [W-1:0]      dsr;
    logic [FRAC_W:0]   sh;
    logic [FRAC_W:0]   q;
    logic [IT_W-1:0]   iter;
    logic [W:0]        trial;
    logic              ge;
    logic [W-1:0]      rem_nx;
    logic [FRAC_W:0]   q_nx;

    // One restoring step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        trial  = {rem, sh[FRAC_W]};
        ge     = trial >= {1'b0, dsr};
        rem_nx = ge ? W'(trial - {1'b0, dsr}) : trial[W-1:0];
        q_nx   = {q[FRAC_W-1:0], ge};
    end

    // done is raised during the final iteration so the caller can register
    // the finished quotient on the same edge the divider retires
    assign done = busy && (iter == IT_W'(1));
    assign quo  = q_nx;

    // Load operands on start, then iterate until the bit counter runs out.
    // The dividend's upper part (num >> 1) seeds the remainder; its low
    // FRAC_W+1 bits ({num[0], zeros}) are shifted in one per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            iter <= '0;
            rem  <= '0;
            dsr  <= '0;
            sh   <= '0;
            q    <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            iter <= IT_W'(FRAC_W + 1);
            rem  <= num >> 1;
            dsr  <= den;
            sh   <= {num[0], {FRAC_W{1'b0}}};
            q    <= '0;
        end else if (busy) begin
            rem  <= rem_nx;
            sh   <= {sh[FRAC_W-1:0], 1'b0};
            q    <= q_nx;
            iter <= iter - 1'b1;
            if (iter == IT_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures an incoming PWM waveform: period in clk cycles and duty on the
// generator's 10-bit scale, with stuck-input detection and overrun flag.
module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DUTY_W  = 10,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TO_LIM   = CNT_W'(TIMEOUT);
    // Saturated duty code; equals DUTY_FULL at the default width
    localparam logic [DUTY_W-1:0] DUTY_SAT = '1;

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] per_lat;
    logic             armed;
    logic             to_fired;
    logic             launch;
    logic             to_hit;
    cap_state_t       state;

    logic             div_busy;
    logic             div_done;
    logic [DUTY_W:0]  quo;

    assign rise   = s2 & ~s3;
    assign launch = rise & armed & (state == ST_IDLE) & ~div_busy;
    // A rise on the threshold cycle wins; a timeout fires once per gap
    assign to_hit = (cnt >= TO_LIM) & ~rise & ~to_fired;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Period and high-time counters; both restart at 1 on each rise so they
    // hold exactly P and H when the next rise arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else begin
            if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (s2 && hcnt != CNT_MAX)
                hcnt <= hcnt + 1'b1;
        end
    end

    // The divider captures the high-count snapshot as its numerator at launch;
    // hcnt never exceeds cnt, so the quotient is at most full scale + 1
    seq_divider #(
        .W      (CNT_W),
        .FRAC_W (DUTY_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .start  (launch),
        .num    (hcnt),
        .den    (cnt),
        .busy   (div_busy),
        .done   (div_done),
        .quo    (quo)
    );

    // Sequencer: arming, launch, result/timeout publication, overrun flag.
    // Results are written on the edge entering DONE so valid coincides with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            to_fired <= 1'b0;
            per_lat  <= '0;
            duty     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            stuck    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            if (rise) begin
                to_fired <= 1'b0;
                armed    <= 1'b1;
            end
            if (rise && state != ST_IDLE)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        per_lat <= cnt;
                        state   <= ST_DIV;
                    end else if (to_hit) begin
                        armed    <= 1'b0;
                        to_fired <= 1'b1;
                        stuck    <= 1'b1;
                        period   <= '0;
                        duty     <= s2 ? DUTY_SAT : '0;
                        valid    <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        duty   <= quo[DUTY_W] ? DUTY_SAT : quo[DUTY_W-1:0];
                        period <= per_lat;
                        stuck  <= 1'b0;
                        valid  <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomized and directed bench for pwm_duty_capture. The reference model
// works on rising-edge timestamps: each rise measures the interval since
// the previous one, and results/overruns are expected at fixed offsets.
module tb_pwm_duty_capture;
    import pwm_duty_capture_pkg::*;

    localparam int TO = TIMEOUT_DEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [9:0]  duty;
    logic [31:0] period;
    logic        valid, stuck, overrun;

    pwm_duty_capture #(.CNT_W(32), .DUTY_W(10), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in),
        .duty(duty), .period(period), .valid(valid),
        .stuck(stuck), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] duty;
        logic [31:0] period;
        logic        stuck;
    } exp_t;

    exp_t exp_v[int];
    bit   exp_ov[int];

    int checks = 0, errors = 0;
    bit armed_m = 0, to_fired = 0;
    int last_rise = 0, last_launch = -100000, hi_cnt = 0, to_deadline = -1;
    int nvalid = 0, n_ov_seen = 0, n_ov_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int exp_duty(input int h, input int p);
        int q;
        q = (h * 1024) / p;
        return (q > DUTY_FULL) ? DUTY_FULL : q;
    endfunction

    // Compare this cycle's outputs with whatever the model scheduled for it
    task automatic sample();
        exp_t e;
        bit   ev;
        if (!reset && !to_fired && cyc == to_deadline) begin
            e.duty   = pwm_in ? 32'(DUTY_FULL) : 32'd0;
            e.period = 0;
            e.stuck  = 1'b1;
            exp_v[cyc] = e;
            to_fired = 1;
            armed_m  = 0;
        end
        ev = exp_v.exists(cyc);
        if (valid) nvalid++;
        if (valid || ev) chk("valid", 32'(valid), 32'(ev));
        if (valid && ev) begin
            e = exp_v[cyc];
            chk("duty", 32'(duty), e.duty);
            chk("period", period, e.period);
            chk("stuck", 32'(stuck), 32'(e.stuck));
        end
        if (ev) exp_v.delete(cyc);
        ev = exp_ov.exists(cyc);
        if (overrun) n_ov_seen++;
        if (overrun || ev) chk("overrun", 32'(overrun), 32'(ev));
        if (ev) exp_ov.delete(cyc);
    endtask

    // A rise either arms, overruns a busy divide, or measures the last interval
    task automatic rise_m();
        exp_t e;
        if (!armed_m) begin
            armed_m = 1;
        end else if (cyc - last_launch <= 12) begin
            exp_ov[cyc + 3] = 1;
            n_ov_exp++;
        end else begin
            e.period = 32'(cyc - last_rise);
            e.duty   = 32'(exp_duty(hi_cnt, cyc - last_rise));
            e.stuck  = 1'b0;
            exp_v[cyc + 14] = e;
            last_launch = cyc;
        end
        last_rise   = cyc;
        hi_cnt      = 0;
        to_deadline = cyc + TO + 3;
        to_fired    = 0;
    endtask

    task automatic step(input bit lvl);
        @(negedge clk);
        sample();
        if (lvl && !pwm_in && !reset) rise_m();
        pwm_in = lvl;
        if (lvl) hi_cnt++;
    endtask

    task automatic pulse(input int p, input int h);
        for (int i = 0; i < p; i++) step(i < h);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"}, 32'(duty), 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_stuck"}, 32'(stuck), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        sample();
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        exp_v.delete();
        exp_ov.delete();
        to_deadline = -1;
        armed_m = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        sample();
        reset       = 1'b0;
        armed_m     = 0;
        to_fired    = 0;
        to_deadline = cyc + TO + 1;
        last_launch = -100000;
        last_rise   = cyc;
        hi_cnt      = 0;
    endtask

    initial begin
        int p, h;
        repeat (3) step(0);
        #1;
        chk_zero("rst_init");
        release_reset();

        // Held low from reset: exactly one stuck report, then silence
        nvalid = 0;
        repeat (11 * TO + 10) step(0);
        chk("low_nvalid", nvalid, 1);
        chk("low_stuck", 32'(stuck), 1);
        chk("low_duty", 32'(duty), 0);

        // Steady 50% then 25%, ~100%, ~0%; first rise only re-arms
        nvalid = 0;
        repeat (4) pulse(2000, 1000);
        pulse(2000, 500);
        pulse(2000, 1999);
        pulse(2000, 1);
        pulse(2000, 1000);
        chk("run_stuck", 32'(stuck), 0);

        // Held high: one more result from the rise, then a stuck-high report
        repeat (TO + 20) step(1);
        chk("hi_nvalid", nvalid, 9);
        chk("hi_stuck", 32'(stuck), 1);
        chk("hi_duty", 32'(duty), 32'(DUTY_FULL));
        chk("hi_period", period, 0);

        // Resume: first rise re-arms, next result clears stuck
        repeat (20) step(0);
        repeat (2) pulse(2000, 1000);
        repeat (16) step(1);
        chk("resume_stuck", 32'(stuck), 0);
        chk("resume_duty", 32'(duty), 512);
        repeat (5) step(0);

        // Fast burst: rises during a divide must overrun
        repeat (12) pulse(8, 4);
        repeat (20) step(0);

        // Random waveforms, some fast enough to overrun
        repeat (30) begin
            p = $urandom_range(200, 8);
            h = $urandom_range(p - 1, 1);
            pulse(p, h);
        end
        repeat (20) step(0);

        // Reset in the middle of a divide: result is dropped
        repeat (2) pulse(400, 200);
        repeat (7) step(1);
        assert_reset();
        repeat (3) step(0);
        release_reset();
        nvalid = 0;
        repeat (3) pulse(300, 150);
        repeat (20) step(0);
        chk("post_rst_nvalid", nvalid, 2);

        chk("ovr_count", n_ov_seen, n_ov_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
